// File: rtl/gemm_pkg.sv
// Shared types and defaults for the GEMM tile scheduler.
// Optional watchdog in the scheduler is enabled by GEMM_SCHED_WATCHDOG_EN.
package gemm_pkg;

  localparam int unsigned GEMM_PE_SIZE        = 16;
  localparam int unsigned GEMM_TILE_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FIN     = 3'd6
  } sched_state_e;

  // Lets the base-address math collapse to a shift for power-of-two arrays.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested row/col tile counter (col inner) with latched grid size, last-tile
// flag and registered per-tile base addresses.
module tile_index_counter
  import gemm_pkg::*;
#(
  parameter int unsigned PE_SIZE        = GEMM_PE_SIZE,
  parameter int unsigned TILE_CNT_WIDTH = GEMM_TILE_CNT_WIDTH,
  parameter int unsigned ADDR_WIDTH     = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      clear,
  input  logic                      advance,
  input  logic [TILE_CNT_WIDTH-1:0] row_tiles,
  input  logic [TILE_CNT_WIDTH-1:0] col_tiles,
  output logic [TILE_CNT_WIDTH-1:0] tile_row,
  output logic [TILE_CNT_WIDTH-1:0] tile_col,
  output logic [ADDR_WIDTH-1:0]     mem0_base,
  output logic [ADDR_WIDTH-1:0]     mem1_base,
  output logic                      last_c
);

  localparam int unsigned SHIFT = $clog2(PE_SIZE);

  logic [TILE_CNT_WIDTH-1:0] row_cnt_q, col_cnt_q;
  logic [TILE_CNT_WIDTH-1:0] row_d, col_d;
  logic                      col_last_c;

  // Overflow past ADDR_WIDTH wraps silently.
  function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic [TILE_CNT_WIDTH-1:0] idx);
    if (is_pow2(PE_SIZE)) return ADDR_WIDTH'(32'(idx) << SHIFT);
    return ADDR_WIDTH'(32'(idx) * PE_SIZE);
  endfunction

  assign col_last_c = (tile_col == col_cnt_q - TILE_CNT_WIDTH'(1));
  assign last_c     = col_last_c && (tile_row == row_cnt_q - TILE_CNT_WIDTH'(1));

  always_comb begin
    row_d = tile_row;
    col_d = tile_col;
    if (load || clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_last_c) begin
        col_d = '0;
        row_d = tile_row + TILE_CNT_WIDTH'(1);
      end else begin
        col_d = tile_col + TILE_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      tile_row  <= '0;
      tile_col  <= '0;
      mem0_base <= '0;
      mem1_base <= '0;
    end else begin
      if (load) begin
        row_cnt_q <= row_tiles;
        col_cnt_q <= col_tiles;
      end
      tile_row  <= row_d;
      tile_col  <= col_d;
      mem0_base <= base_addr(row_d);
      mem1_base <= base_addr(col_d);
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Top-level GEMM tile sequencer: load -> launch -> compute -> drain per tile.
// Define GEMM_SCHED_WATCHDOG_EN to add the LOAD/COMPUTE timeout watchdog.
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int unsigned PE_SIZE        = GEMM_PE_SIZE,
  parameter int unsigned TILE_CNT_WIDTH = GEMM_TILE_CNT_WIDTH,
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned DRAIN_CYCLES   = 2 * PE_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [TILE_CNT_WIDTH-1:0] row_tiles_i,
  input  logic [TILE_CNT_WIDTH-1:0] col_tiles_i,
  output logic                      mover_en_o,
  input  logic                      mover_ld_done_i,
  output logic                      sa_start_o,
  input  logic                      sa_done_i,
  output logic [ADDR_WIDTH-1:0]     mem0_base_o,
  output logic [ADDR_WIDTH-1:0]     mem1_base_o,
  output logic [TILE_CNT_WIDTH-1:0] tile_row_o,
  output logic [TILE_CNT_WIDTH-1:0] tile_col_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  sched_state_e       state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               idx_load, idx_clear, idx_advance;
  logic               last_c, counts_zero_c;

  assign counts_zero_c = (row_tiles_i == '0) || (col_tiles_i == '0);

  tile_index_counter #(
    .PE_SIZE        (PE_SIZE),
    .TILE_CNT_WIDTH (TILE_CNT_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .load      (idx_load),
    .clear     (idx_clear),
    .advance   (idx_advance),
    .row_tiles (row_tiles_i),
    .col_tiles (col_tiles_i),
    .tile_row  (tile_row_o),
    .tile_col  (tile_col_o),
    .mem0_base (mem0_base_o),
    .mem1_base (mem1_base_o),
    .last_c    (last_c)
  );

`ifdef GEMM_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_active_c, wd_expired_c, wd_trip_c;

  assign wd_active_c  = (state_q == ST_LOAD) || (state_q == ST_COMPUTE);
  assign wd_expired_c = wd_active_c && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every entry to a wait state; error is sticky until a new start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      error_o  <= 1'b0;
    end else begin
      if ((state_d != state_q) && ((state_d == ST_LOAD) || (state_d == ST_COMPUTE)))
        wd_cnt_q <= '0;
      else if (wd_active_c)
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wd_trip_c)
        error_o <= 1'b1;
      else if (idx_load)
        error_o <= 1'b0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign error_o        = 1'b0;
`endif

  // Next-state logic; abort has the final word over every other event.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    idx_load    = 1'b0;
    idx_clear   = 1'b0;
    idx_advance = 1'b0;
`ifdef GEMM_SCHED_WATCHDOG_EN
    wd_trip_c   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          idx_load = 1'b1;
          state_d  = counts_zero_c ? ST_FIN : ST_LOAD;
        end
      end
      ST_LOAD:   if (mover_ld_done_i) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_COMPUTE;
      ST_COMPUTE: begin
        if (sa_done_i) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_NEXT;
          end else begin
            drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_NEXT;
        else               drain_d = drain_q - DRAIN_W'(1);
      end
      ST_NEXT: begin
        if (last_c) begin
          state_d = ST_FIN;
        end else begin
          idx_advance = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef GEMM_SCHED_WATCHDOG_EN
    if (wd_expired_c) begin
      state_d   = ST_IDLE;
      wd_trip_c = 1'b1;
    end
`endif
    if (abort_i) begin
      state_d     = ST_IDLE;
      idx_load    = 1'b0;
      idx_advance = 1'b0;
      idx_clear   = 1'b1;
`ifdef GEMM_SCHED_WATCHDOG_EN
      wd_trip_c   = 1'b0;
`endif
    end
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      mover_en_o <= 1'b0;
      sa_start_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      mover_en_o <= (state_d == ST_LOAD);
      sa_start_o <= (state_d == ST_LAUNCH);
      busy_o     <= (state_d != ST_IDLE);
      done_o     <= (state_d == ST_FIN);
    end
  end

endmodule
